pipe_stage_reg: RTL

- Parametrised successor to the fixed-width write-enable register; serves as the inter-stage latch of the pipelined datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, synchronous flush for bubble insertion, and an optional 2-entry skid buffer so in_ready is registered.
- Adds a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_reg.sv | 92 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline latch with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SKID        = 1'b1,
  parameter int               CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             pop;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;

  // Skid mode decodes in_ready from state alone so upstream never sees out_ready.
  generate
    if (SKID) begin : g_skid
      assign in_ready = (state != FULL);
    end else begin : g_noskid
      assign in_ready = !out_valid || out_ready;
    end
  endgenerate

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= EMPTY;
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else if (flush) begin
      // Handshakes in this cycle still complete; their data is simply dropped.
      state  <= EMPTY;
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          if (accept && (pop || !SKID)) begin
            main_q <= in_data;
          end else if (accept) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Counts backpressure cycles; saturates instead of wrapping, survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule
